// File: rtl/bcd_timer_core.sv
// mm:ss BCD timekeeping core with up/down count, adjust mode and terminal-count DONE state.
// Optional display lap-hold is built when LAP_HOLD_EN is defined.
module bcd_timer_core #(
  parameter int unsigned MIN_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_run,
  input  logic                      tick_adj,
  input  logic                      adj,
  input  logic                      sel,
  input  logic                      pause_p,
  input  logic                      clr_p,
  input  logic                      dir,
`ifdef LAP_HOLD_EN
  input  logic                      lap_p,
`endif
  output logic [3:0]                sec_ones,
  output logic [3:0]                sec_tens,
  output logic [4*MIN_DIGITS-1:0]   min_bcd,
  output logic                      running,
  output logic                      expired,
  output logic                      blink
);

  localparam int unsigned MW = 4 * MIN_DIGITS;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_ADJ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      sec_q, sec_d;
  logic [MW-1:0]   min_q, min_d;
  logic            blink_q, blink_d;
  logic            disp_upd_c;
  logic            cnt_zero_c;

  // Seconds as {tens, ones}; 59 wraps to 00.
  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    if (s[3:0] == 4'd9) begin
      if (s[7:4] == 4'd5) return 8'h00;
      return {s[7:4] + 4'd1, 4'd0};
    end
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] sec_dec(input logic [7:0] s);
    if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    return {s[7:4], s[3:0] - 4'd1};
  endfunction

  // Multi-digit BCD increment; all-nines wraps to zero.
  function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          c;
    r = m;
    c = 1'b1;
    for (int i = 0; i < int'(MIN_DIGITS); i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          b;
    r = m;
    b = 1'b1;
    for (int i = 0; i < int'(MIN_DIGITS); i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign cnt_zero_c = (sec_q == 8'h00) && (min_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      sec_q   <= 8'h00;
      min_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      blink_q <= blink_d;
    end
  end

  // Priority: clr_p > adj > pause_p > tick.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    blink_d = blink_q;

    if (clr_p) begin
      sec_d = 8'h00;
      min_d = '0;
      if (state_q == S_DONE || (state_q == S_ADJ && !adj)) state_d = S_PAUSE;
    end else if (adj) begin
      state_d = S_ADJ;
      if (state_q == S_ADJ && tick_adj) begin
        blink_d = ~blink_q;
        if (sel) sec_d = sec_inc(sec_q);
        else     min_d = min_inc(min_q);
      end
    end else if (state_q == S_ADJ) begin
      state_d = S_PAUSE;
    end else if (pause_p && (state_q == S_RUN || state_q == S_PAUSE)) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end else if (state_q == S_RUN && tick_run) begin
      if (dir) begin
        if (cnt_zero_c) begin
          state_d = S_DONE;
        end else if (sec_q == 8'h00) begin
          sec_d = 8'h59;
          min_d = min_dec(min_q);
        end else begin
          sec_d = sec_dec(sec_q);
        end
      end else begin
        sec_d = sec_inc(sec_q);
        if (sec_q == 8'h59) min_d = min_inc(min_q);
      end
    end

    if (state_d != S_ADJ) blink_d = 1'b0;
  end

`ifdef LAP_HOLD_EN
  logic hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (clr_p || adj) hold_d = 1'b0;
    else if (lap_p)   hold_d = ~hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= hold_d;
  end

  assign disp_upd_c = ~hold_q;
`else
  assign disp_upd_c = 1'b1;
`endif

  // Output stage; status flags always follow the live state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_bcd  <= '0;
      running  <= 1'b1;
      expired  <= 1'b0;
      blink    <= 1'b0;
    end else begin
      if (disp_upd_c) begin
        sec_ones <= sec_q[3:0];
        sec_tens <= sec_q[7:4];
        min_bcd  <= min_q;
      end
      running <= (state_q == S_RUN);
      expired <= (state_q == S_DONE);
      blink   <= blink_q;
    end
  end

endmodule

// File: tb/tb_bcd_timer_core.sv
// Bench for bcd_timer_core: integer-seconds reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_bcd_timer_core;

  localparam int MD   = 2;
  localparam int MAXM = 99;
  localparam int M_RUN = 0, M_PAUSE = 1, M_ADJ = 2, M_DONE = 3;

  logic            clk, rst;
  logic            tick_run, tick_adj, adj, sel, pause_p, clr_p, dir, lap_p;
  logic [3:0]      sec_ones, sec_tens;
  logic [4*MD-1:0] min_bcd;
  logic            running, expired, blink;

  bcd_timer_core #(.MIN_DIGITS(MD)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_run (tick_run),
    .tick_adj (tick_adj),
    .adj      (adj),
    .sel      (sel),
    .pause_p  (pause_p),
    .clr_p    (clr_p),
    .dir      (dir),
`ifdef LAP_HOLD_EN
    .lap_p    (lap_p),
`endif
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_bcd  (min_bcd),
    .running  (running),
    .expired  (expired),
    .blink    (blink)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // reference model state
  int m_sec, m_min, m_st, tot;
  bit m_blink, m_hold;
  int e_sec, e_min;
  bit e_run, e_exp, e_blink;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4*MD-1:0] to_bcd(input int v);
    logic [4*MD-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < MD; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: count held as total seconds; display register lags by one cycle.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_sec = 0; m_min = 0; m_st = M_RUN; m_blink = 0; m_hold = 0;
        e_sec = 0; e_min = 0; e_run = 1; e_exp = 0; e_blink = 0;
      end else begin
        if (!m_hold) begin
          e_sec = m_sec;
          e_min = m_min;
        end
        e_run   = (m_st == M_RUN);
        e_exp   = (m_st == M_DONE);
        e_blink = m_blink;
`ifdef LAP_HOLD_EN
        if (clr_p || adj) m_hold = 0;
        else if (lap_p)   m_hold = !m_hold;
`endif
        if (clr_p) begin
          m_sec = 0; m_min = 0;
          if (m_st == M_DONE || (m_st == M_ADJ && !adj)) m_st = M_PAUSE;
        end else if (adj) begin
          if (m_st == M_ADJ && tick_adj) begin
            m_blink = !m_blink;
            if (sel) m_sec = (m_sec + 1) % 60;
            else     m_min = (m_min + 1) % (MAXM + 1);
          end
          m_st = M_ADJ;
        end else if (m_st == M_ADJ) begin
          m_st = M_PAUSE;
        end else if (pause_p && (m_st == M_RUN || m_st == M_PAUSE)) begin
          m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
        end else if (m_st == M_RUN && tick_run) begin
          tot = m_min * 60 + m_sec;
          if (dir) begin
            if (tot == 0) m_st = M_DONE;
            else          tot = tot - 1;
          end else begin
            tot = (tot + 1) % ((MAXM + 1) * 60);
          end
          m_min = tot / 60;
          m_sec = tot % 60;
        end
        if (m_st != M_ADJ) m_blink = 0;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_sec_ones", 32'(sec_ones), 32'(e_sec % 10));
        check("m_sec_tens", 32'(sec_tens), 32'(e_sec / 10));
        check("m_min_bcd",  32'(min_bcd),  32'(to_bcd(e_min)));
        check("m_running",  32'(running),  32'(e_run));
        check("m_expired",  32'(expired),  32'(e_exp));
        check("m_blink",    32'(blink),    32'(e_blink));
      end
    end
  end

  task automatic p_tick();
    tick_run = 1'b1; @(negedge clk); tick_run = 1'b0;
  endtask
  task automatic p_adj();
    tick_adj = 1'b1; @(negedge clk); tick_adj = 1'b0;
  endtask
  task automatic p_pause();
    pause_p = 1'b1; @(negedge clk); pause_p = 1'b0;
  endtask
  task automatic p_clr();
    clr_p = 1'b1; @(negedge clk); clr_p = 1'b0;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk_time(input string name, input int mm, input int ss);
    check({name, "_min"},  32'(min_bcd),  32'(to_bcd(mm)));
    check({name, "_tens"}, 32'(sec_tens), 32'(ss / 10));
    check({name, "_ones"}, 32'(sec_ones), 32'(ss % 10));
  endtask

  initial begin
    rst = 1'b0; tick_run = 0; tick_adj = 0; adj = 0; sel = 0;
    pause_p = 0; clr_p = 0; dir = 0; lap_p = 0;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk_time("reset", 0, 0);
    check("reset_running", 32'(running), 32'd1);
    check("reset_expired", 32'(expired), 32'd0);
    check("reset_blink",   32'(blink),   32'd0);
    rst = 1'b0;
    settle();

    // 60 up-ticks carry into minutes
    repeat (60) p_tick();
    settle();
    check("t1_min_lit", 32'(min_bcd), 32'h01);
    chk_time("t1", 1, 0);

    // adjust to 99:59, then wrap to 00:00
    adj = 1'b1; @(negedge clk);
    sel = 1'b0; repeat (98) p_adj();
    sel = 1'b1; repeat (59) p_adj();
    adj = 1'b0; @(negedge clk);
    settle();
    check("t2_min_lit", 32'(min_bcd), 32'h99);
    chk_time("t2_pre", 99, 59);
    check("t2_paused", 32'(running), 32'd0);
    p_pause();
    p_tick();
    settle();
    chk_time("t2_wrap", 0, 0);
    check("t2_running", 32'(running), 32'd1);

    // down-count into DONE
    repeat (2) p_tick();
    dir = 1'b1;
    p_tick(); settle();
    chk_time("t3_01", 0, 1);
    p_tick(); settle();
    chk_time("t3_00", 0, 0);
    check("t3_not_exp", 32'(expired), 32'd0);
    p_tick(); settle();
    check("t3_expired", 32'(expired), 32'd1);
    check("t3_done_run", 32'(running), 32'd0);
    repeat (2) p_tick();
    settle();
    chk_time("t3_hold", 0, 0);
    check("t3_hold_exp", 32'(expired), 32'd1);
    p_clr(); settle();
    check("t3_clr_exp", 32'(expired), 32'd0);
    check("t3_clr_run", 32'(running), 32'd0);

    // pause and tick in the same cycle: tick discarded
    p_pause();
    dir = 1'b0;
    repeat (10) p_tick();
    pause_p = 1'b1; tick_run = 1'b1; @(negedge clk);
    pause_p = 1'b0; tick_run = 1'b0;
    settle();
    chk_time("t4", 0, 10);
    check("t4_paused", 32'(running), 32'd0);
    p_tick(); settle();
    chk_time("t4_frozen", 0, 10);

    // seconds adjust wraps without carry; blink is parity of tick_adj count (53)
    adj = 1'b1; @(negedge clk);
    sel = 1'b0; repeat (3) p_adj();
    sel = 1'b1; repeat (49) p_adj();
    settle();
    chk_time("t5_pre", 3, 59);
    p_adj(); settle();
    chk_time("t5_wrap", 3, 0);
    check("t5_blink", 32'(blink), 32'd1);
    p_tick(); settle();
    chk_time("t5_tick_ign", 3, 0);
    adj = 1'b0; @(negedge clk);
    settle();
    check("t5_pause", 32'(running), 32'd0);
    check("t5_blink0", 32'(blink), 32'd0);
    p_pause();
    dir = 1'b1;
    p_tick(); settle();
    chk_time("t5_borrow", 2, 59);

`ifdef LAP_HOLD_EN
    // lap hold freezes display while counting continues
    dir = 1'b0;
    p_clr();
    repeat (5) p_tick();
    lap_p = 1'b1; @(negedge clk); lap_p = 1'b0;
    repeat (3) p_tick();
    settle();
    chk_time("t6_hold", 0, 5);
    check("t6_running", 32'(running), 32'd1);
    lap_p = 1'b1; @(negedge clk); lap_p = 1'b0;
    settle();
    chk_time("t6_release", 0, 8);
`endif

    settle();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
